// File: rtl/k_loop_program_counter.sv
// k_loop_program_counter
// Instruction-fetch address generator for the DSP core. Supports stall,
// branch/jump redirect and a nested zero-overhead hardware-loop stack.
// Only the top stack entry is compared against the PC, so inner loops must
// finish before an outer loop's end address can trigger.
//
// There are no handshakes. Every command input is sampled on a rising edge
// only when stall is low. A command that arrives while stall is high is
// dropped, not held for a later cycle.
module k_loop_program_counter #(
    parameter int ADDR_W     = 32,
    parameter int STEP       = 4,
    parameter int RESET_ADDR = 0,
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              branch_en,
    input  logic [ADDR_W-1:0]                 branch_target,
    input  logic                              loop_push,
    input  logic [ADDR_W-1:0]                 loop_end_addr,
    input  logic [CNT_W-1:0]                  loop_count,
    input  logic                              loop_flush,
    output logic [ADDR_W-1:0]                 pc_reg,
    output logic                              loop_active,
    output logic [$clog2(LOOP_DEPTH+1)-1:0]   loop_level,
    output logic                              loop_err
);

    localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    // Loop stack storage. Entries at index r_level and above are invalid.
    logic [ADDR_W-1:0] r_start [LOOP_DEPTH];
    logic [ADDR_W-1:0] r_end   [LOOP_DEPTH];
    logic [CNT_W-1:0]  r_rem   [LOOP_DEPTH];
    logic [LVL_W-1:0]  r_level;
    logic [ADDR_W-1:0] r_pc;
    logic              r_err;

    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_push_idx;
    logic              w_active;
    logic              w_full;
    logic              w_match;
    logic              w_repeat;
    logic              w_push_ok;
    logic              w_push_err;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_next_pc;

    // Stack pointers, end-match detection, push validation and next-PC selection.
    always_comb begin
        w_active   = (r_level != '0);
        w_full     = (r_level == LVL_W'(LOOP_DEPTH));
        w_top_idx  = w_active ? IDX_W'(r_level - LVL_W'(1)) : '0;
        w_push_idx = IDX_W'(r_level);
        w_seq_pc   = r_pc + ADDR_W'(STEP);
        // A branch takes priority over the loop end, so it suppresses the end-match.
        w_match    = w_active && !branch_en && (r_pc == r_end[w_top_idx]);
        w_repeat   = w_match && (r_rem[w_top_idx] > CNT_W'(1));
        // A flush overrides a push in the same cycle. The push is then dropped
        // and raises no error.
        w_push_ok  = loop_push && !loop_flush && !w_full &&
                     (loop_count != '0) && !w_match && !branch_en;
        w_push_err = loop_push && !loop_flush && !w_push_ok;

        w_next_pc = w_seq_pc;
        if (branch_en) begin
            w_next_pc = branch_target;
        end else if (w_repeat) begin
            w_next_pc = r_start[w_top_idx];
        end
    end

    // PC, loop stack and sticky error register. Everything holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= ADDR_W'(RESET_ADDR);
            r_level <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                r_start[i] <= '0;
                r_end[i]   <= '0;
                r_rem[i]   <= '0;
            end
        end else if (!stall) begin
            r_pc <= w_next_pc;
            if (w_push_err) begin
                r_err <= 1'b1;
            end
            if (loop_flush) begin
                r_level <= '0;
            end else if (w_match) begin
                if (w_repeat) begin
                    r_rem[w_top_idx] <= r_rem[w_top_idx] - CNT_W'(1);
                end else begin
                    r_level <= r_level - LVL_W'(1);
                end
            end else if (w_push_ok) begin
                r_start[w_push_idx] <= w_seq_pc;
                r_end[w_push_idx]   <= loop_end_addr;
                r_rem[w_push_idx]   <= loop_count;
                r_level             <= r_level + LVL_W'(1);
            end
        end
    end

    assign pc_reg      = r_pc;
    assign loop_level  = r_level;
    assign loop_active = w_active;
    assign loop_err    = r_err;

endmodule

// File: tb/tb_k_loop_program_counter.sv
// Directed testbench for k_loop_program_counter. The main instance uses the
// default parameters. A second instance with ADDR_W=8 covers PC wrap-around.
module tb_k_loop_program_counter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        loop_push;
    logic [31:0] loop_end_addr;
    logic [15:0] loop_count;
    logic        loop_flush;
    logic [31:0] pc_reg;
    logic        loop_active;
    logic [2:0]  loop_level;
    logic        loop_err;

    logic        b8_en;
    logic [7:0]  b8_target;
    logic [7:0]  pc8;
    logic        active8;
    logic [2:0]  level8;
    logic        err8;

    int checks;
    int failures;

    k_loop_program_counter u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .loop_push     (loop_push),
        .loop_end_addr (loop_end_addr),
        .loop_count    (loop_count),
        .loop_flush    (loop_flush),
        .pc_reg        (pc_reg),
        .loop_active   (loop_active),
        .loop_level    (loop_level),
        .loop_err      (loop_err)
    );

    k_loop_program_counter #(.ADDR_W(8)) u_dut8 (
        .clk           (clk),
        .reset         (reset),
        .stall         (1'b0),
        .branch_en     (b8_en),
        .branch_target (b8_target),
        .loop_push     (1'b0),
        .loop_end_addr (8'h00),
        .loop_count    (16'h0000),
        .loop_flush    (1'b0),
        .pc_reg        (pc8),
        .loop_active   (active8),
        .loop_level    (level8),
        .loop_err      (err8)
    );

    // Clock block: 10-unit period, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs from the expected one.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Outputs are sampled 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        stall         = 1'b0;
        branch_en     = 1'b0;
        branch_target = '0;
        loop_push     = 1'b0;
        loop_end_addr = '0;
        loop_count    = '0;
        loop_flush    = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] target);
        branch_en     = 1'b1;
        branch_target = target;
        step();
        branch_en     = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] end_addr, input logic [15:0] cnt);
        loop_push     = 1'b1;
        loop_end_addr = end_addr;
        loop_count    = cnt;
        step();
        loop_push     = 1'b0;
    endtask

    // Nested-loop vectors. An outer push at pc=0 (end 16, count 2) and an inner
    // push at every visit to pc=4 (end 8, count 2). The inner body starts at 8,
    // so it is a one-instruction loop.
    logic [31:0] nest_pc  [11];
    logic [2:0]  nest_lvl [11];
    int          max_lvl;

    initial begin
        nest_pc  = '{32'd4, 32'd8, 32'd8, 32'd12, 32'd16, 32'd4,
                     32'd8, 32'd8, 32'd12, 32'd16, 32'd20};
        nest_lvl = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1,
                     3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
        checks   = 0;
        failures = 0;
        b8_en     = 1'b0;
        b8_target = '0;
        clear_cmds();

        // Reset, then free-run.
        reset = 1'b1;
        #4;
        check("rst_pc", pc_reg, 32'd0);
        check("rst_level", {29'd0, loop_level}, 32'd0);
        check("rst_active", {31'd0, loop_active}, 32'd0);
        check("rst_err", {31'd0, loop_err}, 32'd0);
        #6;
        reset = 1'b0;
        #2;
        check("free_pc0", pc_reg, 32'd0);
        for (int i = 1; i < 10; i++) begin
            step();
            check($sformatf("free_pc%0d", i), pc_reg, 32'(i * 4));
            check("free_active", {31'd0, loop_active}, 32'd0);
        end

        // Stall and branch. A push issued during the stall must be ignored.
        do_branch(32'd8);
        check("br_to8", pc_reg, 32'd8);
        stall         = 1'b1;
        loop_push     = 1'b1;
        loop_end_addr = 32'd40;
        loop_count    = 16'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", pc_reg, 32'd8);
        end
        check("stall_nopush", {29'd0, loop_level}, 32'd0);
        clear_cmds();
        step();
        check("stall_release", pc_reg, 32'd12);
        do_branch(32'h100);
        check("br_0x100", pc_reg, 32'h100);

        // Single loop: push end=8, count=3 at pc=0.
        do_branch(32'd0);
        do_push(32'd8, 16'd3);
        check("single_pc", pc_reg, 32'd4);
        check("single_lvl_push", {29'd0, loop_level}, 32'd1);
        check("single_active", {31'd0, loop_active}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("single_pc", pc_reg, (i % 2 == 0) ? 32'd8 : 32'd4);
            check("single_lvl", {29'd0, loop_level}, 32'd1);
        end
        step();
        check("single_exit_pc", pc_reg, 32'd12);
        check("single_exit_lvl", {29'd0, loop_level}, 32'd0);

        // Nested loops.
        do_branch(32'd0);
        max_lvl = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) begin
                loop_push = 1'b1; loop_end_addr = 32'd16; loop_count = 16'd2;
            end else if (pc_reg == 32'd4) begin
                loop_push = 1'b1; loop_end_addr = 32'd8;  loop_count = 16'd2;
            end
            step();
            loop_push = 1'b0;
            check($sformatf("nest_pc%0d", i), pc_reg, nest_pc[i]);
            check($sformatf("nest_lvl%0d", i), {29'd0, loop_level}, {29'd0, nest_lvl[i]});
            if (int'(loop_level) > max_lvl) max_lvl = int'(loop_level);
        end
        check("nest_peak", 32'(max_lvl), 32'd2);
        check("nest_err", {31'd0, loop_err}, 32'd0);

        // Fill the stack (pc 20..32), then a fifth push is rejected.
        for (int i = 0; i < 4; i++) begin
            do_push(32'h1000, 16'd5);
        end
        check("full_pc", pc_reg, 32'd36);
        check("full_lvl", {29'd0, loop_level}, 32'd4);
        check("full_err0", {31'd0, loop_err}, 32'd0);
        do_push(32'h1000, 16'd5);
        check("ovf_pc", pc_reg, 32'd40);
        check("ovf_lvl", {29'd0, loop_level}, 32'd4);
        check("ovf_err", {31'd0, loop_err}, 32'd1);

        // Reset mid-loop, away from a clock edge: the effect must be immediate.
        #2;
        reset = 1'b1;
        #1;
        check("arst_pc", pc_reg, 32'd0);
        check("arst_lvl", {29'd0, loop_level}, 32'd0);
        check("arst_active", {31'd0, loop_active}, 32'd0);
        check("arst_err", {31'd0, loop_err}, 32'd0);
        #1;
        reset = 1'b0;

        // Flush overrides a simultaneous push without flagging an error.
        do_push(32'h80, 16'd2);
        check("fl_pc", pc_reg, 32'd4);
        check("fl_lvl_before", {29'd0, loop_level}, 32'd1);
        loop_flush = 1'b1;
        do_push(32'h80, 16'd2);
        loop_flush = 1'b0;
        check("fl_pc_after", pc_reg, 32'd8);
        check("fl_lvl_after", {29'd0, loop_level}, 32'd0);
        check("fl_err", {31'd0, loop_err}, 32'd0);

        // A push with count=0 is rejected.
        do_push(32'h80, 16'd0);
        check("cnt0_pc", pc_reg, 32'd12);
        check("cnt0_lvl", {29'd0, loop_level}, 32'd0);
        check("cnt0_err", {31'd0, loop_err}, 32'd1);

        // 8-bit wrap: 0xF8 -> 0xFC -> 0x00.
        b8_en     = 1'b1;
        b8_target = 8'hF8;
        step();
        b8_en     = 1'b0;
        check("w8_f8", {24'd0, pc8}, 32'hF8);
        step();
        check("w8_fc", {24'd0, pc8}, 32'hFC);
        step();
        check("w8_wrap", {24'd0, pc8}, 32'h00);
        check("w8_err", {31'd0, err8}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
